// File: rtl/msrv32_alu_pkg.sv
// Shared ALU opcode codes, response-slot FSM encodings and the ALU request bundle
// used by the two-requester ALU arbiter.
package msrv32_alu_pkg;

    // Opcode is {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    typedef struct packed {
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [3:0]  opcode;
    } alu_req_t;

endpackage

// File: rtl/msrv32_alu.sv
// Combinational RV32I integer ALU; codes outside the defined set yield zero.
module msrv32_alu
    import msrv32_alu_pkg::*;
(
    input  logic [31:0] op_1_in,
    input  logic [31:0] op_2_in,
    input  logic [3:0]  opcode_in,
    output logic [31:0] result_out
);

    logic [4:0] shamt;
    assign shamt = op_2_in[4:0];

    always_comb begin
        result_out = '0;
        case (opcode_in)
            ALU_ADD:  result_out = op_1_in + op_2_in;
            ALU_SUB:  result_out = op_1_in - op_2_in;
            ALU_SLL:  result_out = op_1_in << shamt;
            ALU_SLT:  result_out = {31'b0, $signed(op_1_in) < $signed(op_2_in)};
            ALU_SLTU: result_out = {31'b0, op_1_in < op_2_in};
            ALU_XOR:  result_out = op_1_in ^ op_2_in;
            ALU_SRL:  result_out = op_1_in >> shamt;
            ALU_SRA:  result_out = $unsigned($signed(op_1_in) >>> shamt);
            ALU_OR:   result_out = op_1_in | op_2_in;
            ALU_AND:  result_out = op_1_in & op_2_in;
            default:  result_out = '0;
        endcase
    end

endmodule

// File: rtl/msrv32_alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a single registered
// response slot (EMPTY/FULL) that supports same-cycle take and refill.
module msrv32_alu_arbiter
    import msrv32_alu_pkg::*;
#(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        req0_valid_in,
    output logic        req0_ready_out,
    input  logic [31:0] req0_op_1_in,
    input  logic [31:0] req0_op_2_in,
    input  logic [3:0]  req0_opcode_in,
    input  logic        req1_valid_in,
    output logic        req1_ready_out,
    input  logic [31:0] req1_op_1_in,
    input  logic [31:0] req1_op_2_in,
    input  logic [3:0]  req1_opcode_in,
    output logic        resp_valid_out,
    input  logic        resp_ready_in,
    output logic [31:0] resp_result_out,
    output logic        resp_id_out,
    output logic        dbg_state_out,
    output logic        dbg_prio_out
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, ready is combinational from valid and slot state.
    logic        state_q, state_d;
    logic        prio_q, prio_d;
    logic [31:0] result_q, result_d;
    logic        id_q, id_d;

    logic        slot_free;
    logic        gnt_valid;
    logic        gnt_id;
    logic        accept;
    alu_req_t    alu_req;
    logic [31:0] alu_result;

    always_comb begin
        gnt_valid = req0_valid_in | req1_valid_in;
        gnt_id    = (req0_valid_in && req1_valid_in) ? prio_q : req1_valid_in;
        slot_free = (state_q == ST_EMPTY) || resp_ready_in;
        accept    = gnt_valid && slot_free && !ms_riscv32_mp_rst_in;

        req0_ready_out = accept && !gnt_id;
        req1_ready_out = accept && gnt_id;

        alu_req = gnt_id ? '{req1_op_1_in, req1_op_2_in, req1_opcode_in}
                         : '{req0_op_1_in, req0_op_2_in, req0_opcode_in};
    end

    msrv32_alu u_alu (
        .op_1_in    (alu_req.op_1),
        .op_2_in    (alu_req.op_2),
        .opcode_in  (alu_req.opcode),
        .result_out (alu_result)
    );

    // An accept always wins over a take, which is what gives back-to-back refill.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        result_d = result_q;
        id_d     = id_q;
        if (accept) begin
            state_d  = ST_FULL;
            result_d = alu_result;
            id_d     = gnt_id;
            prio_d   = ~gnt_id;
        end else if (state_q == ST_FULL && resp_ready_in) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q  <= ST_EMPTY;
            prio_q   <= PRIO_INIT;
            result_q <= '0;
            id_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            result_q <= result_d;
            id_q     <= id_d;
        end
    end

    assign resp_valid_out  = (state_q == ST_FULL);
    assign resp_result_out = result_q;
    assign resp_id_out     = id_q;
    assign dbg_state_out   = state_q;
    assign dbg_prio_out    = prio_q;

endmodule
